// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT defaults, packed complex type, twiddle FSM states and cosine table helper
package fft_pkg;
    localparam int WIDTH_DEF = 24;
    localparam int LOG2N_DEF = 6;
    localparam int HALF_DEF  = WIDTH_DEF / 2;
    localparam int FRAC_ONE  = 2 ** (HALF_DEF - 2);
    typedef struct packed {
        logic signed [HALF_DEF-1:0] re;
        logic signed [HALF_DEF-1:0] im;
    } cplx_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam longint PI_Q30 = 64'sd3373259426;
    // round(2^frac * cos(2*pi*n/nn)) for angles in [0, pi/2], via a Q30 Taylor series so the
    // table is built at elaboration without real arithmetic
    function automatic longint cos_round(input int n, input int nn, input int frac);
        longint x, x2, term, sum;
        x    = (PI_Q30 * 2 * longint'(n)) / longint'(nn);
        x2   = (x * x) >>> 30;
        term = 64'sd1 <<< 30;
        sum  = term;
        for (int i = 1; i < 12; i++) begin
            term = -((term * x2) >>> 30) / longint'((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        return ((sum <<< frac) + (64'sd1 <<< 29)) >>> 30;
    endfunction
endpackage

// File: rtl/twiddle_rom.sv
// twiddle_rom: quarter-wave cosine table C[0..Q], two registered read ports on one advance enable
//   clk, rst           clock, asynchronous active-high reset
//   en                 advance enable shared with the twiddle pipeline
//   addr_a_i, addr_b_i read addresses (0..Q)
//   data_a_o, data_b_o registered C[addr_a_i], C[addr_b_i]
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LOG2N = LOG2N_DEF,
    localparam int H  = WIDTH / 2,
    localparam int Q  = 2 ** (LOG2N - 2),
    localparam int AW = $clog2(Q + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] addr_a_i,
    input  logic [AW-1:0] addr_b_i,
    output logic [H-1:0]  data_a_o,
    output logic [H-1:0]  data_b_o
);
    logic [H-1:0] rom [Q+1];
    logic [H-1:0] data_a_q, data_b_q;
    for (genvar i = 0; i <= Q; i++) begin : g_rom
        localparam logic [H-1:0] CV = H'(cos_round(i, 4 * Q, H - 2));
        assign rom[i] = CV;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else if (en) begin
            data_a_q <= rom[addr_a_i];
            data_b_q <= rom[addr_b_i];
        end
    end
    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;
endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: streams radix-2 DIT twiddles W_N^k as packed {re, im} for every butterfly of every stage
//   clk, rst   clock, asynchronous active-high reset
//   start      begin a full sequence (ignored unless idle)
//   out_ready  consumer accepts w this cycle
//   inv        (only with TWIDDLE_INV_EN) emit conj(W) for the whole sequence, sampled on start
//   out_valid  w valid
//   w          twiddle {re, im}, each half WIDTH/2-bit two's complement, 1.0 = 2^(WIDTH/2-2)
//   stage      stage index of w
//   last       final word of the sequence
//   busy       sequence in progress
//   done       one-cycle pulse after the final handshake
// Optional feature macro: TWIDDLE_INV_EN
module twiddle_gen
    import fft_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LOG2N = LOG2N_DEF,
    localparam int SW = $clog2(LOG2N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             out_ready,
`ifdef TWIDDLE_INV_EN
    input  logic             inv,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] w,
    output logic [SW-1:0]    stage,
    output logic             last,
    output logic             busy,
    output logic             done
);
    localparam int H  = WIDTH / 2;
    localparam int Q  = 2 ** (LOG2N - 2);
    localparam int KW = LOG2N - 1;
    localparam int AW = $clog2(Q + 1);

    state_t           state_q, state_d;
    logic [SW-1:0]    s_q, s_d, st0_q, st1_q, stage_q;
    logic [KW-1:0]    b_q, b_d, mask, k_d, k_q;
    logic             v0_q, v1_q, out_valid_q;
    logic             last0_q, last1_q, last_q, neg1_q, done_q, inv_q;
    logic [WIDTH-1:0] w_q;
    logic [AW-1:0]    addr_a, addr_b;
    logic [H-1:0]     rom_a, rom_b, re, im;
    logic             en, fin, issue, accept_last;

    assign en          = !out_valid_q || out_ready;
    assign fin         = s_q == SW'(LOG2N - 1) && &b_q;
    assign issue       = state_q == RUN && en;
    assign accept_last = out_valid_q && out_ready && last_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        mask    = '0;
        for (int j = 0; j < KW; j++) mask[j] = j < int'(s_q);
        k_d = (b_q & mask) << (SW'(LOG2N - 1) - s_q);
        if (state_q == IDLE && start) state_d = RUN;
        if (issue) begin
            b_d     = b_q + 1'b1;
            s_d     = fin ? '0 : (&b_q ? s_q + 1'b1 : s_q);
            state_d = fin ? DRAIN : RUN;
        end
        if (state_q == DRAIN && accept_last) state_d = IDLE;
    end

    // Fold k into the first quadrant: port a feeds re, port b feeds im
    assign addr_a = AW'(int'(k_q) <= Q ? int'(k_q) : 2 * Q - int'(k_q));
    assign addr_b = AW'(int'(k_q) <= Q ? Q - int'(k_q) : int'(k_q) - Q);

    twiddle_rom #(.WIDTH(WIDTH), .LOG2N(LOG2N)) u_rom (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .addr_a_i (addr_a),
        .addr_b_i (addr_b),
        .data_a_o (rom_a),
        .data_b_o (rom_b)
    );

    assign re = neg1_q ? -rom_a : rom_a;
    assign im = inv_q ? rom_b : -rom_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            b_q         <= '0;
            v0_q        <= 1'b0;
            k_q         <= '0;
            st0_q       <= '0;
            last0_q     <= 1'b0;
            v1_q        <= 1'b0;
            st1_q       <= '0;
            last1_q     <= 1'b0;
            neg1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            w_q         <= '0;
            stage_q     <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            done_q  <= state_q == DRAIN && accept_last;
            if (en) begin
                v0_q        <= state_q == RUN;
                k_q         <= k_d;
                st0_q       <= s_q;
                last0_q     <= state_q == RUN && fin;
                v1_q        <= v0_q;
                st1_q       <= st0_q;
                last1_q     <= last0_q;
                neg1_q      <= int'(k_q) > Q;
                out_valid_q <= v1_q;
                w_q         <= {re, im};
                stage_q     <= st1_q;
                last_q      <= last1_q;
            end
        end
    end

`ifdef TWIDDLE_INV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inv_q <= 1'b0;
        else if (state_q == IDLE && start) inv_q <= inv;
    end
`else
    assign inv_q = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign w         = w_q;
    assign stage     = stage_q;
    assign last      = last_q;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: directed checks of the N=64, WIDTH=24 twiddle stream against a hand-computed cosine table
module tb_twiddle_gen;
    logic        clk = 1'b0;
    logic        rst, start, out_ready;
`ifdef TWIDDLE_INV_EN
    logic        inv = 1'b0;
`endif
    logic        out_valid, last, busy, done;
    logic [23:0] w;
    logic [2:0]  stage;
    int          checks = 0;
    int          failures = 0;
    int          cos_t [17] = '{1024, 1019, 1004, 980, 946, 903, 851, 792, 724,
                                650, 569, 483, 392, 297, 200, 100, 0};

    always #5 clk = ~clk;

    twiddle_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .out_ready (out_ready),
`ifdef TWIDDLE_INV_EN
        .inv       (inv),
`endif
        .out_valid (out_valid),
        .w         (w),
        .stage     (stage),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_w(input int s, input int b, input bit iv);
        int k, re, im;
        logic [11:0] r12, i12;
        k = (b % (1 << s)) << (5 - s);
        if (k <= 16) begin
            re = cos_t[k];
            im = -cos_t[16 - k];
        end else begin
            re = -cos_t[32 - k];
            im = -cos_t[k - 16];
        end
        if (iv) im = -im;
        r12 = 12'(re);
        i12 = 12'(im);
        return {r12, i12};
    endfunction

    task automatic run_seq(input bit rnd, input bit restart, input int abort_at, input bit iv);
        int idx, cyc, first_v, hold;
        bit stalled, saw_done, held;
        logic [23:0] pw;
        logic [2:0] ps;
        idx = 0; cyc = 0; first_v = -1; hold = 0;
        stalled = 0; saw_done = 0; held = 0;
        pw = '0; ps = '0;
        @(negedge clk);
        start = 1'b1;
`ifdef TWIDDLE_INV_EN
        inv = iv;
`endif
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (idx < 192 && cyc < 3000) begin
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_valid", out_valid, 0);
                check("abort_w", w, 0);
                check("abort_stage", stage, 0);
                check("abort_last", last, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                end
                rst = 1'b0;
                return;
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd && idx == 112 && !held) begin
                held = 1;
                hold = 10;
            end
            if (hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end
            start = restart && cyc == 20;
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_w", w, pw);
                check("stall_stage", stage, ps);
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (done) saw_done = 1;
            if (out_valid && out_ready) begin
                check("w", w, exp_w(idx / 32, idx % 32, iv));
                check("stage", stage, idx / 32);
                check("last", last, idx == 191);
                if (idx < 32) check("s0_one", w, 24'h400000);
                if (idx == 168) check("k8", w, iv ? 24'h2D42D4 : 24'h2D4D2C);
                if (idx == 176) check("k16", w, iv ? 24'h000400 : 24'h000C00);
                if (idx == 184) check("k24", w, iv ? 24'hD2C2D4 : 24'hD2CD2C);
                idx++;
            end
            stalled = out_valid && !out_ready;
            pw = w;
            ps = stage;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("count", idx, 192);
        check("latency", first_v, 3);
        check("early_done", saw_done, 0);
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        repeat (10) @(negedge clk);
        check("idle_valid", out_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_w", w, 0);
        check("rst_stage", stage, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        run_seq(0, 0, -1, 0);
        run_seq(1, 1, -1, 0);
        run_seq(0, 0, 50, 0);
        run_seq(0, 0, -1, 0);
`ifdef TWIDDLE_INV_EN
        run_seq(0, 0, -1, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
